// File: rtl/hilo_mul_if.sv
// hilo_mul_if: EX-stage multiply request/response bundle between the pipeline
// and the HI/LO multiply unit. The master issues multu/maddu requests and
// observes busy/done/HI/LO. The slave is the multiply unit itself.
interface hilo_mul_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             sel2;
    logic             flush;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, sel2, flush, src_a, src_b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, sel2, flush, src_a, src_b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/hilo_mul_unit.sv
// hilo_mul_unit: shift-and-add unsigned multiplier plus the HI/LO register pair.
// multu overwrites {hi,lo}; maddu adds the product into {hi,lo} modulo 2^(2*WIDTH).
// Optional macro HILO_MUL_EARLY_EXIT_EN: leave RUN as soon as the remaining
// multiplier bits are all zero, which shortens latency for small operands.
module hilo_mul_unit #(
    parameter int WIDTH = 32
) (
    input logic       clk,
    input logic       rst,
    hilo_mul_if.slave bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ACC  = 2'd2
    } state_t;

    state_t           state_q,  state_d;
    logic [PW-1:0]    mcand_q,  mcand_d;
    logic [PW-1:0]    prod_q,   prod_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] hi_q,     hi_d;
    logic [WIDTH-1:0] lo_q,     lo_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic             mode_q,   mode_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic             last_iter;

    // Accumulate with wraparound: carry out of the top HI bit is dropped.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] x,
                                               input logic [PW-1:0] y);
        return x + y;
    endfunction

    // Decide whether the current RUN iteration is the final one.
    always_comb begin
`ifdef HILO_MUL_EARLY_EXIT_EN
        last_iter = (cnt_q == CW'(WIDTH - 1)) || ((mplier_q >> 1) == '0);
`else
        last_iter = (cnt_q == CW'(WIDTH - 1));
`endif
    end

    // Next-state and datapath logic for the IDLE/RUN/ACC sequencer.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        mplier_d = mplier_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                // flush squashes a simultaneous start
                if (bus.start && !bus.flush) begin
                    mcand_d  = {{WIDTH{1'b0}}, bus.src_a};
                    mplier_d = bus.src_b;
                    mode_d   = bus.sel2;
                    prod_d   = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    if (mplier_q[0]) begin
                        prod_d = prod_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 1'b1;
                    if (last_iter) begin
                        state_d = ACC;
                    end
                end
            end
            ACC: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    if (mode_q) begin
                        {hi_d, lo_d} = wrap_add({hi_q, lo_q}, prod_q);
                    end else begin
                        {hi_d, lo_d} = prod_q;
                    end
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Register all state; reset clears everything, including HI/LO.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            mode_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            mplier_q <= mplier_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_hilo_mul_unit.sv
// tb_hilo_mul_unit: directed and random multu/maddu sequences checked against
// a 64-bit arithmetic model of the HI/LO pair and a latency formula.
module tb_hilo_mul_unit;
    localparam int WIDTH = 32;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [63:0] model_hilo;

    hilo_mul_if #(.WIDTH(WIDTH)) bus ();

    hilo_mul_unit #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Cycles from the start edge to the first cycle showing done.
    function automatic int exp_lat(input logic [31:0] b);
`ifdef HILO_MUL_EARLY_EXIT_EN
        int iters;
        iters = 1;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) iters = i + 1;
        end
        return iters + 2;
`else
        return WIDTH + 2;
`endif
    endfunction

    // Issue one operation in the current cycle and follow it until done or a
    // cycle bound. inj_kind: 0 none, 1 stray start, 2 flush, 3 reset at cycle inj_n.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic mode,
                          input int inj_n, input int inj_kind,
                          output int lat, output int busy_cyc, output bit got_done);
        int n;
        bit chk_after;
        bus.start = 1'b1;
        bus.src_a = a;
        bus.src_b = b;
        bus.sel2  = mode;
        step();
        bus.start = 1'b0;
        bus.src_a = $urandom;
        bus.src_b = $urandom;
        bus.sel2  = 1'($urandom);
        n = 1;
        lat = 0;
        busy_cyc = 0;
        got_done = 1'b0;
        while (n < 60) begin
            if (bus.done === 1'b1) begin
                got_done = 1'b1;
                lat = n;
                break;
            end
            if (bus.busy === 1'b1) busy_cyc++;
            chk_after = 1'b0;
            if (n == inj_n) begin
                if (inj_kind == 1) begin
                    bus.start = 1'b1;
                    bus.src_a = 32'd100;
                    bus.src_b = 32'd100;
                    bus.sel2  = 1'b0;
                end else if (inj_kind == 2) begin
                    bus.flush = 1'b1;
                    chk_after = 1'b1;
                end else if (inj_kind == 3) begin
                    rst = 1'b0;
                    chk_after = 1'b1;
                end
            end
            step();
            bus.start = 1'b0;
            bus.flush = 1'b0;
            rst = 1'b1;
            if (chk_after) begin
                check("abort_busy", 64'(bus.busy), 64'd0);
                if (inj_kind == 3) begin
                    check("rst_hi", 64'(bus.hi), 64'd0);
                    check("rst_lo", 64'(bus.lo), 64'd0);
                    check("rst_done", 64'(bus.done), 64'd0);
                end
            end
            n++;
        end
    endtask

    // Run a clean operation, update the model, and check result and timing.
    task automatic op_check(input logic [31:0] a, input logic [31:0] b, input logic mode,
                            input int inj_n, input int inj_kind, input string tag);
        int lat;
        int busy_cyc;
        bit got_done;
        logic [63:0] prod;
        run_op(a, b, mode, inj_n, inj_kind, lat, busy_cyc, got_done);
        prod = 64'(a) * 64'(b);
        model_hilo = mode ? (model_hilo + prod) : prod;
        check({tag, "_done"}, 64'(got_done), 64'd1);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat(b)));
        check({tag, "_busycyc"}, 64'(busy_cyc), 64'(exp_lat(b) - 1));
        check({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
        check({tag, "_hilo"}, {bus.hi, bus.lo}, model_hilo);
    endtask

    initial begin
        int lat;
        int busy_cyc;
        int inj;
        bit got_done;
        logic [31:0] ra;
        logic [31:0] rb;
        logic rm;

        checks = 0;
        errors = 0;
        model_hilo = 64'd0;
        rst = 1'b0;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.sel2 = 1'b0;
        bus.src_a = '0;
        bus.src_b = '0;
        step();
        step();
        step();
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_hi", 64'(bus.hi), 64'd0);
        check("reset_lo", 64'(bus.lo), 64'd0);
        rst = 1'b1;
        step();

        // Basic multu and spec values
        op_check(32'd3, 32'd5, 1'b0, 0, 0, "mul3x5");
        check("mul3x5_const", {bus.hi, bus.lo}, 64'h0000_0000_0000_000F);
        op_check(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 0, "mulmax");
        check("mulmax_const", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
        op_check(32'd2, 32'd3, 1'b1, 0, 0, "madd2x3");
        check("madd2x3_const", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0007);

        // Build all-ones HI/LO, then wrap with maddu 1x1
        op_check(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 0, "wrap_a");
        op_check(32'hFFFF_FFFF, 32'd2, 1'b1, 0, 0, "wrap_b");
        check("allones_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFF);
        op_check(32'd1, 32'd1, 1'b1, 0, 0, "wrap_c");
        check("wrap_const", {bus.hi, bus.lo}, 64'd0);

        // Stray start while running is ignored
        inj = (exp_lat(32'd9) > 12) ? 10 : 2;
        op_check(32'd7, 32'd9, 1'b0, inj, 1, "stray");
        check("stray_const", {bus.hi, bus.lo}, 64'd63);

        // Flush mid-operation: no done, HI/LO keep prior value
        op_check(32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 0, 0, "preflush");
        run_op(32'd7, 32'd9, 1'b0, inj, 2, lat, busy_cyc, got_done);
        check("flush_nodone", 64'(got_done), 64'd0);
        check("flush_hilo", {bus.hi, bus.lo}, model_hilo);

        // Reset in the middle of a maddu
        run_op(32'hCAFE_F00D, 32'h8000_0005, 1'b1, 20, 3, lat, busy_cyc, got_done);
        model_hilo = 64'd0;
        check("midrst_nodone", 64'(got_done), 64'd0);
        check("midrst_hilo", {bus.hi, bus.lo}, model_hilo);

        // flush and start together in IDLE: nothing accepted
        op_check(32'd11, 32'd13, 1'b0, 0, 0, "prefs");
        step();
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.src_a = 32'd5;
        bus.src_b = 32'd5;
        bus.sel2 = 1'b1;
        step();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("fs_busy1", 64'(bus.busy), 64'd0);
        step();
        check("fs_busy2", 64'(bus.busy), 64'd0);
        check("fs_done", 64'(bus.done), 64'd0);
        check("fs_hilo", {bus.hi, bus.lo}, model_hilo);

        // Latency extremes (short only when early exit is built in)
        op_check(32'h1234, 32'd1, 1'b0, 0, 0, "ee_one");
        check("ee_one_const", {bus.hi, bus.lo}, 64'h1234);
        op_check(32'h0F0F_0F0F, 32'd0, 1'b1, 0, 0, "ee_zero");
        op_check(32'd3, 32'h8000_0000, 1'b0, 0, 0, "ee_top");
        check("ee_top_const", {bus.hi, bus.lo}, 64'h0000_0001_8000_0000);

        // Random back-to-back operations
        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 1) rb = rb >> (1 + ($urandom % 31));
            rm = 1'($urandom);
            op_check(ra, rb, rm, 0, 0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
